// File: rtl/jtmx5k_sdram_resp_if.sv
// Game-side bus of the SDRAM responder: single-word ROM reads plus byte-masked
// download writes, both acknowledged through the shared sdram_ack pulse.
interface jtmx5k_sdram_resp_if;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;

  modport master (
    output downloading, prog_addr, prog_data, prog_mask, prog_we, sdram_req, sdram_addr,
    input  sdram_ack, data_dst, data_rdy, data_read
  );

  modport slave (
    input  downloading, prog_addr, prog_data, prog_mask, prog_we, sdram_req, sdram_addr,
    output sdram_ack, data_dst, data_rdy, data_read
  );
endinterface

// File: rtl/jtmx5k_sdram_resp.sv
// Responder between the game request bus and a fixed-latency 16-bit memory port.
// Optional periodic refresh is built in when MX5K_RESP_REFRESH_EN is defined.
module jtmx5k_sdram_resp #(
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 384,
  parameter int REF_LEN    = 4
)(
  input  logic        clk,
  input  logic        rst,
  jtmx5k_sdram_resp_if.slave bus,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  output logic        mem_ref
);

  if (RD_LAT < 1 || RD_LAT > 7 || REF_PERIOD < 2 || REF_LEN < 1) begin : g_bad_param
    $error("jtmx5k_sdram_resp: parameter out of range");
  end

`ifdef MX5K_RESP_REFRESH_EN
  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DATA, GAP, REF} state_t;
  localparam int RW = $clog2(REF_PERIOD);
  localparam int LW = $clog2(REF_LEN + 1);
  logic [RW-1:0] ref_cnt;
  logic [LW-1:0] ref_len_cnt;
  logic          ref_pend;
`else
  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DATA, GAP} state_t;
  assign mem_ref = 1'b0;
`endif

  state_t     st;
  logic [2:0] lat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      lat_cnt       <= '0;
      bus.sdram_ack <= 1'b0;
      bus.data_dst  <= 1'b0;
      bus.data_rdy  <= 1'b0;
      bus.data_read <= '0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
`ifdef MX5K_RESP_REFRESH_EN
      mem_ref       <= 1'b0;
      ref_cnt       <= '0;
      ref_len_cnt   <= '0;
      ref_pend      <= 1'b0;
`endif
    end else begin
      bus.sdram_ack <= 1'b0;
      bus.data_dst  <= 1'b0;
      bus.data_rdy  <= 1'b0;
      mem_rd        <= 1'b0;
      mem_we        <= 1'b0;
`ifdef MX5K_RESP_REFRESH_EN
      // Free-running period counter; a second expiry while pending is absorbed.
      if (ref_cnt == RW'(REF_PERIOD - 1)) begin
        ref_cnt  <= '0;
        ref_pend <= 1'b1;
      end else begin
        ref_cnt  <= ref_cnt + 1'b1;
      end
`endif
      case (st)
        IDLE: begin
`ifdef MX5K_RESP_REFRESH_EN
          if (ref_pend) begin
            st          <= REF;
            mem_ref     <= 1'b1;
            ref_len_cnt <= LW'(REF_LEN);
          end else
`endif
          if (bus.downloading && bus.prog_we) begin
            st            <= WR;
            mem_we        <= 1'b1;
            bus.sdram_ack <= 1'b1;
            mem_addr      <= bus.prog_addr;
            mem_wdata     <= {bus.prog_data, bus.prog_data};
            mem_wmask     <= ~bus.prog_mask;
          end else if (!bus.downloading && bus.sdram_req) begin
            st            <= RD_WAIT;
            mem_rd        <= 1'b1;
            bus.sdram_ack <= 1'b1;
            mem_addr      <= bus.sdram_addr;
            lat_cnt       <= 3'(RD_LAT);
          end
        end
        WR: st <= GAP;
        // data_dst leads data_rdy by one cycle, so it fires as the count hits 1.
        RD_WAIT: begin
          if (lat_cnt == 3'd1) begin
            bus.data_dst <= 1'b1;
            st           <= RD_DATA;
          end else begin
            lat_cnt      <= lat_cnt - 3'd1;
          end
        end
        RD_DATA: begin
          bus.data_read <= mem_rdata;
          bus.data_rdy  <= 1'b1;
          st            <= GAP;
        end
        GAP: st <= IDLE;
`ifdef MX5K_RESP_REFRESH_EN
        REF: begin
          if (ref_len_cnt == LW'(1)) begin
            mem_ref  <= 1'b0;
            ref_pend <= 1'b0;
            st       <= GAP;
          end else begin
            ref_len_cnt <= ref_len_cnt - 1'b1;
          end
        end
`endif
        default: st <= IDLE;
      endcase
    end
  end

endmodule
